// File: rtl/cpair_frame_src_pkg.sv
// Shared types and constants for the complex-pair frame sequencer and its consumer model.
package cpair_frame_src_pkg;

  localparam int FRAME_LEN = 4;
  localparam int CMULT_LAT = 5;
  localparam int OP_W      = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic signed [OP_W-1:0] ar;
    logic signed [OP_W-1:0] ai;
    logic signed [OP_W-1:0] br;
    logic signed [OP_W-1:0] bi;
  } pair_t;

endpackage

// File: rtl/cpair_frame_src_if.sv
// Operand write port and frame output port of the complex-pair sequencer.
interface cpair_frame_src_if
  import cpair_frame_src_pkg::*;
#(
  parameter int N = OP_W
);

  logic                wr_en;
  logic signed [N-1:0] wr_ar, wr_ai, wr_br, wr_bi;
  logic                full;
  logic                overflow;
  logic signed [N-1:0] out_ar, out_ai, out_br, out_bi;
  logic                out_valid;
  logic                out_first;
  logic                out_last;
  logic                sum_valid;

  modport master (
    input  wr_en, wr_ar, wr_ai, wr_br, wr_bi,
    output full, overflow,
    output out_ar, out_ai, out_br, out_bi,
    output out_valid, out_first, out_last, sum_valid
  );

  modport slave (
    output wr_en, wr_ar, wr_ai, wr_br, wr_bi,
    input  full, overflow,
    input  out_ar, out_ai, out_br, out_bi,
    input  out_valid, out_first, out_last, sum_valid
  );

endinterface

// File: rtl/cpair_fifo.sv
// Operand-pair FIFO: storage, wrapping pointers, occupancy, full flag and sticky overflow.
module cpair_fifo
  import cpair_frame_src_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  pair_t                    din,
  input  logic                     pop,
  output pair_t                    dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     push_ok
);

  localparam int AW = $clog2(DEPTH);

  pair_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            overflow_reg;
  logic            pop_ok;

  // Full is judged on the registered count, so a same-cycle pop never makes room for a push.
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && (count_reg != '0);
  assign dout     = mem[rd_ptr_reg];
  assign count    = count_reg;
  assign overflow = overflow_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      if (push && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpair_frame_src.sv
// Issues buffered operand pairs as gap-free 4-beat frames and flags when the
// downstream window sum covers exactly one frame.
module cpair_frame_src
  import cpair_frame_src_pkg::*;
#(
  parameter int Q     = 8,
  parameter int N     = 16,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  cpair_frame_src_if.master  bus
);

  localparam int              CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     FRAME_MIN = (CW+1)'(FRAME_LEN);

  // Q only describes the operand format; an integer-only format makes no sense here.
  if (Q >= N) begin : g_q_check
    $error("cpair_frame_src: Q must be smaller than N");
  end

  pair_t              wr_pair;
  pair_t              head;
  pair_t              out_pair_reg;
  logic [CW-1:0]      count;
  logic               fifo_full;
  logic               fifo_ovf;
  logic               push_ok;
  logic               pop;
  logic [CW:0]        avail_after;

  state_t             state_reg, state_next;
  logic [1:0]         beat_reg, beat_next;
  logic               out_valid_reg, out_first_reg, out_last_reg;
  logic [CMULT_LAT-1:0] lat_reg;

  assign wr_pair = '{ar: bus.wr_ar, ai: bus.wr_ai, br: bus.wr_br, bi: bus.wr_bi};

  cpair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.wr_en),
    .din      (wr_pair),
    .pop      (pop),
    .dout     (head),
    .count    (count),
    .full     (fifo_full),
    .overflow (fifo_ovf),
    .push_ok  (push_ok)
  );

  // Occupancy seen next cycle once this cycle's pop and accepted push land.
  assign avail_after = {1'b0, count} + (CW+1)'(push_ok) - (CW+1)'(1);

  // beat_reg names the beat being popped this cycle; it is registered onto out_* next cycle.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if ({1'b0, count} >= FRAME_MIN) begin
          pop        = 1'b1;
          beat_next  = 2'd1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        pop       = 1'b1;
        beat_next = beat_reg + 2'd1;
        if (beat_reg == 2'd3 && avail_after < FRAME_MIN) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      beat_reg      <= 2'd0;
      out_valid_reg <= 1'b0;
      out_first_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_pair_reg  <= '0;
      lat_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      out_valid_reg <= pop;
      out_first_reg <= pop && (beat_reg == 2'd0);
      out_last_reg  <= pop && (beat_reg == 2'd3);
      out_pair_reg  <= pop ? head : '0;
      lat_reg       <= {lat_reg[CMULT_LAT-2:0], out_last_reg};
    end
  end

  assign bus.out_ar    = out_pair_reg.ar;
  assign bus.out_ai    = out_pair_reg.ai;
  assign bus.out_br    = out_pair_reg.br;
  assign bus.out_bi    = out_pair_reg.bi;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_first = out_first_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.sum_valid = lat_reg[CMULT_LAT-1];
  assign bus.full      = fifo_full;
  assign bus.overflow  = fifo_ovf;

endmodule

// File: tb/tb_cpair_frame_src.sv
// Self-checking bench: vector table plus hand sequences, scoreboarded beats and a
// consumer model that forms the 4-product window sum with the consumer latency.
`timescale 1ns/1ps
module tb_cpair_frame_src;
  import cpair_frame_src_pkg::*;

  localparam int Q     = 8;
  localparam int N     = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpair_frame_src_if #(.N(N)) bus ();

  cpair_frame_src #(.Q(Q), .N(N), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Standalone FIFO for the fill/overflow corner, which the sequencer never reaches.
  logic                   f_rst = 1'b1;
  logic                   f_push = 1'b0;
  logic                   f_pop = 1'b0;
  pair_t                  f_din = '0;
  pair_t                  f_dout;
  logic [$clog2(DEPTH):0] f_count;
  logic                   f_full, f_ovf, f_push_ok;

  cpair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (f_rst),
    .push     (f_push),
    .din      (f_din),
    .pop      (f_pop),
    .dout     (f_dout),
    .count    (f_count),
    .full     (f_full),
    .overflow (f_ovf),
    .push_ok  (f_push_ok)
  );

  typedef struct {
    int n;
    int gap;
    int mode;
    int beats;
    int frames;
  } vec_t;

  vec_t   vecs [5];
  pair_t  q_pairs [$];
  longint q_sum_r [$], q_sum_i [$];
  int     q_sv_exp [$];
  int     log_vld [$], log_sv [$];
  longint log_sum_r [$], log_sum_i [$];
  longint acc_r, acc_i;
  int     acc_n;
  int     last_wr_cyc;

  function automatic void check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic longint prod_r(input pair_t p);
    return (longint'(p.ar) * longint'(p.br) - longint'(p.ai) * longint'(p.bi)) >>> Q;
  endfunction

  function automatic longint prod_i(input pair_t p);
    return (longint'(p.ar) * longint'(p.bi) + longint'(p.ai) * longint'(p.br)) >>> Q;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_acc();
    acc_r = 0;
    acc_i = 0;
    acc_n = 0;
  endtask

  task automatic clear_logs();
    log_vld.delete();
    log_sv.delete();
    log_sum_r.delete();
    log_sum_i.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_acc();
    tick(2);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wr(input pair_t p);
    bus.wr_en = 1'b1;
    bus.wr_ar = p.ar;
    bus.wr_ai = p.ai;
    bus.wr_br = p.br;
    bus.wr_bi = p.bi;
    q_pairs.push_back(p);
    acc_r += prod_r(p);
    acc_i += prod_i(p);
    acc_n++;
    if (acc_n == FRAME_LEN) begin
      q_sum_r.push_back(acc_r);
      q_sum_i.push_back(acc_i);
      acc_r = 0;
      acc_i = 0;
      acc_n = 0;
    end
    last_wr_cyc = cyc;
    tick(1);
    bus.wr_en = 1'b0;
    bus.wr_ar = '0;
    bus.wr_ai = '0;
    bus.wr_br = '0;
    bus.wr_bi = '0;
  endtask

  // Beat scoreboard plus consumer model (4-product window, CMULT_LAT cycles later).
  longint ph_r [4], ph_i [4], wd_r [6], wd_i [6];
  int     bidx = 0;
  pair_t  mon_o, mon_e;
  longint win_r, win_i;

  always @(negedge clk) begin
    mon_o = '{ar: bus.out_ar, ai: bus.out_ai, br: bus.out_br, bi: bus.out_bi};
    if (rst) begin
      q_pairs.delete();
      q_sum_r.delete();
      q_sum_i.delete();
      q_sv_exp.delete();
      bidx = 0;
      for (int k = 0; k < 4; k++) begin ph_r[k] = 0; ph_i[k] = 0; end
      for (int k = 0; k < 6; k++) begin wd_r[k] = 0; wd_i[k] = 0; end
    end else begin
      if (bus.out_valid) begin
        log_vld.push_back(cyc);
        $display("beat cyc=%0d idx=%0d ar=%0d ai=%0d br=%0d bi=%0d",
                 cyc, bidx, bus.out_ar, bus.out_ai, bus.out_br, bus.out_bi);
        check_eq("out_first", longint'(bus.out_first), longint'(bidx == 0));
        check_eq("out_last", longint'(bus.out_last), longint'(bidx == 3));
        if (q_pairs.size() == 0) begin
          check_eq("unexpected_beat", 1, 0);
        end else begin
          mon_e = q_pairs.pop_front();
          check_eq("beat_data", longint'(mon_o), longint'(mon_e));
        end
        if (bidx == 3) q_sv_exp.push_back(cyc + CMULT_LAT);
        bidx = (bidx + 1) % 4;
      end else begin
        check_eq("idle_outputs_zero",
                 longint'(mon_o != '0 || bus.out_first || bus.out_last), 0);
      end
      for (int k = 3; k > 0; k--) begin ph_r[k] = ph_r[k-1]; ph_i[k] = ph_i[k-1]; end
      ph_r[0] = prod_r(mon_o);
      ph_i[0] = prod_i(mon_o);
      win_r = ph_r[0] + ph_r[1] + ph_r[2] + ph_r[3];
      win_i = ph_i[0] + ph_i[1] + ph_i[2] + ph_i[3];
      for (int k = 5; k > 0; k--) begin wd_r[k] = wd_r[k-1]; wd_i[k] = wd_i[k-1]; end
      wd_r[0] = win_r;
      wd_i[0] = win_i;
      if (bus.sum_valid) begin
        log_sv.push_back(cyc);
        $display("sum cyc=%0d r=%0d i=%0d", cyc, wd_r[5], wd_i[5]);
        if (q_sv_exp.size() == 0) check_eq("unexpected_sum_valid", 1, 0);
        else check_eq("sum_valid_time", cyc, q_sv_exp.pop_front());
        if (q_sum_r.size() == 0) begin
          check_eq("sum_missing", 1, 0);
        end else begin
          check_eq("sum_r", wd_r[5], q_sum_r.pop_front());
          check_eq("sum_i", wd_i[5], q_sum_i.pop_front());
          log_sum_r.push_back(wd_r[5]);
          log_sum_i.push_back(wd_i[5]);
        end
      end
    end
  end

  int    c0;
  int    w4;
  pair_t p;
  pair_t fd [10];

  initial begin
    vecs[0] = '{n: 4,  gap: 0, mode: 1, beats: 4,  frames: 1};
    vecs[1] = '{n: 8,  gap: 0, mode: 2, beats: 8,  frames: 2};
    vecs[2] = '{n: 20, gap: 0, mode: 0, beats: 20, frames: 5};
    vecs[3] = '{n: 7,  gap: 0, mode: 0, beats: 4,  frames: 1};
    vecs[4] = '{n: 12, gap: 1, mode: 0, beats: 12, frames: 3};

    bus.wr_en = 1'b0;
    bus.wr_ar = '0;
    bus.wr_ai = '0;
    bus.wr_br = '0;
    bus.wr_bi = '0;
    clear_acc();
    tick(1);
    do_reset();

    check_eq("rst_out_valid", longint'(bus.out_valid), 0);
    check_eq("rst_out_operands", longint'({bus.out_ar, bus.out_ai, bus.out_br, bus.out_bi}), 0);
    check_eq("rst_flags", longint'({bus.out_first, bus.out_last, bus.sum_valid}), 0);
    check_eq("rst_full", longint'(bus.full), 0);
    check_eq("rst_overflow", longint'(bus.overflow), 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      c0 = cyc;
      for (int i = 0; i < vecs[v].n; i++) begin
        case (vecs[v].mode)
          1: p = '{ar: 16'sd256, ai: 16'sd0, br: 16'sd256, bi: 16'sd0};
          2: p = '{ar: 16'(256 * i), ai: 16'sd0, br: 16'sd256, bi: 16'sd256};
          default: p = '{ar: 16'($urandom), ai: 16'($urandom),
                         br: 16'($urandom), bi: 16'($urandom)};
        endcase
        wr(p);
        if (vecs[v].gap > 0) tick(vecs[v].gap);
      end
      tick(30);
      check_eq($sformatf("v%0d_beats", v), log_vld.size(), vecs[v].beats);
      check_eq($sformatf("v%0d_frames", v), log_sv.size(), vecs[v].frames);
      check_eq($sformatf("v%0d_leftover", v), q_pairs.size(), vecs[v].n - vecs[v].beats);
      check_eq($sformatf("v%0d_pending_sum_valid", v), q_sv_exp.size(), 0);
      check_eq($sformatf("v%0d_full", v), longint'(bus.full), 0);
      check_eq($sformatf("v%0d_overflow", v), longint'(bus.overflow), 0);
      if (vecs[v].gap == 0 && log_vld.size() == vecs[v].beats && log_sv.size() == vecs[v].frames) begin
        check_eq($sformatf("v%0d_first_beat_cycle", v), log_vld[0] - c0, 5);
        check_eq($sformatf("v%0d_beats_contiguous", v),
                 log_vld[log_vld.size()-1] - log_vld[0], vecs[v].beats - 1);
        check_eq($sformatf("v%0d_first_sum_cycle", v), log_sv[0] - c0, 13);
        for (int k = 1; k < log_sv.size(); k++) begin
          check_eq($sformatf("v%0d_sum_spacing", v), log_sv[k] - log_sv[k-1], 4);
        end
      end
      if (vecs[v].mode == 1 && log_sum_r.size() == 1) begin
        check_eq("unity_r_out", log_sum_r[0], 1024);
        check_eq("unity_i_out", log_sum_i[0], 0);
      end
      if (vecs[v].mode == 2 && log_sum_r.size() == 2) begin
        check_eq("ramp_frame0_r", log_sum_r[0], 1536);
        check_eq("ramp_frame0_i", log_sum_i[0], 1536);
        check_eq("ramp_frame1_r", log_sum_r[1], 5632);
        check_eq("ramp_frame1_i", log_sum_i[1], 5632);
      end
    end

    // Three pairs never start a frame; the fourth, 10 cycles later, starts one 2 cycles on.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr('{ar: 16'(i + 1), ai: 16'(-i), br: 16'sd300, bi: 16'sd7});
    end
    tick(9);
    check_eq("three_pairs_no_beat", log_vld.size(), 0);
    wr('{ar: 16'sd50, ai: 16'sd60, br: 16'sd70, bi: 16'sd80});
    w4 = last_wr_cyc;
    tick(14);
    check_eq("fourth_write_beats", log_vld.size(), 4);
    if (log_vld.size() > 0) check_eq("fourth_write_latency", log_vld[0] - w4, 2);
    check_eq("fourth_write_frames", log_sv.size(), 1);

    // Reset on beat 2 abandons the frame, empties the FIFO and kills pending sum_valid.
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      wr('{ar: 16'(10 * i), ai: 16'sd1, br: 16'sd256, bi: 16'sd2});
    end
    tick(1);
    check_eq("midrst_beat2_valid", longint'(bus.out_valid), 1);
    check_eq("midrst_beat2_flags", longint'({bus.out_first, bus.out_last}), 0);
    check_eq("midrst_beat2_cycle", cyc - c0, 7);
    rst = 1'b1;
    clear_acc();
    tick(1);
    rst = 1'b0;
    clear_logs();
    check_eq("midrst_out_valid", longint'(bus.out_valid), 0);
    check_eq("midrst_operands", longint'({bus.out_ar, bus.out_ai, bus.out_br, bus.out_bi}), 0);
    check_eq("midrst_flags", longint'({bus.out_first, bus.out_last, bus.sum_valid}), 0);
    tick(15);
    check_eq("midrst_no_sum_valid", log_sv.size(), 0);
    check_eq("midrst_no_beats", log_vld.size(), 0);
    for (int i = 0; i < 3; i++) begin
      wr('{ar: 16'sd5, ai: 16'sd6, br: 16'sd7, bi: 16'sd8});
    end
    tick(10);
    check_eq("midrst_fifo_emptied", log_vld.size(), 0);

    // Fill and overflow on a bare FIFO.
    f_rst = 1'b1;
    tick(1);
    f_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fd[i] = '{ar: 16'(i + 1), ai: 16'(100 + i), br: 16'(-3 * i), bi: 16'(1000 - i)};
    end
    for (int i = 0; i < 8; i++) begin
      f_push = 1'b1;
      f_din  = fd[i];
      tick(1);
      $display("fifo push i=%0d count=%0d", i, f_count);
    end
    f_push = 1'b0;
    check_eq("fifo_full_after_8", longint'(f_full), 1);
    check_eq("fifo_count_after_8", longint'(f_count), 8);
    check_eq("fifo_ovf_before_drop", longint'(f_ovf), 0);
    f_push = 1'b1;
    f_din  = fd[8];
    tick(1);
    f_push = 1'b0;
    check_eq("fifo_ovf_after_drop", longint'(f_ovf), 1);
    check_eq("fifo_count_after_drop", longint'(f_count), 8);
    tick(3);
    check_eq("fifo_ovf_sticky", longint'(f_ovf), 1);
    check_eq("fifo_head_0", longint'(f_dout), longint'(fd[0]));
    f_push = 1'b1;
    f_pop  = 1'b1;
    f_din  = fd[9];
    tick(1);
    f_push = 1'b0;
    f_pop  = 1'b0;
    check_eq("fifo_push_pop_at_full_count", longint'(f_count), 7);
    check_eq("fifo_push_pop_at_full_full", longint'(f_full), 0);
    for (int i = 1; i < 8; i++) begin
      check_eq($sformatf("fifo_head_%0d", i), longint'(f_dout), longint'(fd[i]));
      f_pop = 1'b1;
      tick(1);
      f_pop = 1'b0;
    end
    check_eq("fifo_drained_count", longint'(f_count), 0);
    check_eq("fifo_ovf_held", longint'(f_ovf), 1);
    f_rst = 1'b1;
    tick(1);
    f_rst = 1'b0;
    check_eq("fifo_ovf_cleared_by_rst", longint'(f_ovf), 0);
    check_eq("fifo_count_after_rst", longint'(f_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
